sng_stream_ctrl: RTL
====================

Name: sng_stream_ctrl

Overview:
- Stochastic number generator (SNG) controller that sits directly upstream and downstream of the width-parameterised XNOR LFSR.
- Drives the LFSR's enable and seed-load inputs, and consumes its state output.
- Each run converts one binary operand into a unipolar bitstream of one full LFSR period (2^WIDTH-1 bits) by comparing the operand with the LFSR state every cycle.
- Also counts the ones it emits, for self-check and for downstream accumulation.

Parameters:
WIDTH, 3, operand/LFSR width; legal range 3..32; must equal the NUM_BITS of the attached LFSR.
SEED_INIT, 0, reset value of the internal seed register; used only when ROTATE_SEED_EN is defined; must not be all-ones.

Ports:
clk  input  1  clock, rising edge.
rst  input  1  asynchronous, active-high reset.
in_valid  input  1  operand/seed offered.
in_ready  output  1  controller can accept an operand (high only in IDLE).
in_data  input  WIDTH  binary operand (unsigned).
in_seed  input  WIDTH  LFSR seed for this run.
lfsr_enable  output  1  to LFSR enable.
lfsr_seed_dv  output  1  to LFSR seed data-valid.
lfsr_seed_data  output  WIDTH  to LFSR seed data.
lfsr_data  input  WIDTH  LFSR state output.
bit_out  output  1  stochastic bit, registered.
bit_valid  output  1  bit_out qualifier.
ones_count  output  WIDTH  ones emitted in the current/last run.
busy  output  1  high in SEED and RUN.
done  output  1  one-cycle pulse at end of run.

Behaviour:
- Reset (async, rst=1) clears all of the following:
  - state=IDLE.
  - bit_out, bit_valid, done, busy, lfsr_enable, lfsr_seed_dv = 0.
  - lfsr_seed_data = 0, ones_count = 0.
  - operand and cycle-counter registers.
  - In ROTATE_SEED_EN builds, the seed register loads SEED_INIT.
- Reset mid-run aborts with no done pulse.
- IDLE:
  - in_ready=1, lfsr_enable=0.
  - On in_valid&&in_ready: latch in_data and the seed, clear ones_count and the cycle counter, then go to SEED.
  - An all-ones seed (the XNOR lockup state) is replaced by 0 when latched.
- SEED (1 cycle):
  - lfsr_enable=1, lfsr_seed_dv=1, lfsr_seed_data=latched seed, busy=1.
  - Then go to RUN.
- RUN (exactly 2^WIDTH-1 cycles):
  - lfsr_enable=1, lfsr_seed_dv=0, busy=1.
  - Each cycle: cmp = (lfsr_data < operand), unsigned compare.
  - bit_out<=cmp, bit_valid<=1, ones_count+=cmp.
  - The cycle counter runs 0..2^WIDTH-2; on its terminal value go to DONE.
  - The counter is WIDTH bits wide; there is no wrap within a run.
- DONE (1 cycle):
  - done=1, lfsr_enable=0.
  - bit_valid=1 in this cycle only, carrying the last bit.
  - Then go to IDLE.
- bit_valid is low in IDLE and SEED.
- Since the LFSR visits every value except all-ones once per period, the final ones_count equals the operand exactly for any in_data in 0..2^WIDTH-1.
- ones_count holds its final value until the next acceptance.
- Timing with acceptance at cycle T:
  - SEED at T+1.
  - RUN at T+2..T+2^WIDTH.
  - DONE at T+2^WIDTH+1.
  - in_ready high again at T+2^WIDTH+2.
- in_valid is ignored while not in IDLE; there is no queuing.
- done and in_valid never interact, because in_ready=0 during DONE.
- No internal arithmetic exceeds WIDTH bits.

Optional Feature:
ROTATE_SEED_EN:
- Defined:
  - in_seed is ignored.
  - Each run uses the internal seed register, which resets to SEED_INIT.
  - On the DONE cycle the register rotates left by 1; rotation preserves "not all-ones".
  - Successive runs therefore use decorrelated LFSR phases without host involvement.
- Undefined: the seed register and rotation logic are absent, and every run uses in_seed as latched at acceptance.

Test Plan:
1. WIDTH=3, in_data=5, in_seed=0 -> SEED 1 cycle with lfsr_seed_dv=1 and seed_data=0; 7 bit_valid cycles; done at T+9; ones_count=5.
2. in_data=0, then in_data=7 -> all seven bits 0 and ones_count=0; then all seven bits 1 and ones_count=7.
3. in_seed=3'b111 -> lfsr_seed_data=0 during SEED; run completes normally with ones_count=in_data.
4. in_valid held high through a run, with a second operand=2 -> accepted only at T+10 when in_ready=1; second run gives ones_count=2.
5. rst asserted mid-RUN (cycle T+4) -> all outputs 0 immediately, no done pulse, in_ready=1 after release.
6. ROTATE_SEED_EN, SEED_INIT=3'b001, three back-to-back runs -> seeds loaded 001, 010, 100; each ones_count equals its operand.

Source files
------------

// File: rtl/sng_stream_ctrl.sv
// Stochastic number generator controller: drives an external XNOR LFSR and emits one full-period unipolar bitstream per operand.
// Optional feature macro: ROTATE_SEED_EN (internal self-rotating seed register replaces in_seed).
module sng_stream_ctrl #(
  parameter int               WIDTH     = 3,
  parameter logic [WIDTH-1:0] SEED_INIT = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [WIDTH-1:0] in_seed,
  output logic             lfsr_enable,
  output logic             lfsr_seed_dv,
  output logic [WIDTH-1:0] lfsr_seed_data,
  input  logic [WIDTH-1:0] lfsr_data,
  output logic             bit_out,
  output logic             bit_valid,
  output logic [WIDTH-1:0] ones_count,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEED = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  // Last RUN cycle index: a period is 2^WIDTH-1 cycles, counted 0..2^WIDTH-2.
  localparam logic [WIDTH-1:0] CNT_LAST = {{(WIDTH-1){1'b1}}, 1'b0};

  state_t           state;
  logic [WIDTH-1:0] operand_r;
  logic [WIDTH-1:0] cnt_r;
  logic [WIDTH-1:0] seed_src;
  logic             cmp;

  // All-ones is the XNOR lockup state and must never be loaded.
  function automatic logic [WIDTH-1:0] fix_seed(input logic [WIDTH-1:0] s);
    if (s == {WIDTH{1'b1}}) begin
      fix_seed = {WIDTH{1'b0}};
    end else begin
      fix_seed = s;
    end
  endfunction

`ifdef ROTATE_SEED_EN
  logic [WIDTH-1:0] seed_r;
  logic             unused_seed;

  assign seed_src    = seed_r;
  assign unused_seed = ^in_seed;

  // Rotation keeps at least one zero bit, so the register never reaches lockup.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seed_r <= SEED_INIT;
    end else if (state == S_DONE) begin
      seed_r <= {seed_r[WIDTH-2:0], seed_r[WIDTH-1]};
    end else begin
      seed_r <= seed_r;
    end
  end
`else
  logic unused_cfg;

  assign seed_src   = in_seed;
  assign unused_cfg = ^{1'b0, SEED_INIT};
`endif

  assign cmp = (lfsr_data < operand_r);

  // Control FSM; every output is registered and set on the transition into its state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= S_IDLE;
      in_ready       <= 1'b1;
      lfsr_enable    <= 1'b0;
      lfsr_seed_dv   <= 1'b0;
      lfsr_seed_data <= {WIDTH{1'b0}};
      bit_out        <= 1'b0;
      bit_valid      <= 1'b0;
      ones_count     <= {WIDTH{1'b0}};
      busy           <= 1'b0;
      done           <= 1'b0;
      operand_r      <= {WIDTH{1'b0}};
      cnt_r          <= {WIDTH{1'b0}};
    end else begin
      case (state)
        S_IDLE: begin
          bit_valid <= 1'b0;
          done      <= 1'b0;
          if (in_valid && in_ready) begin
            state          <= S_SEED;
            in_ready       <= 1'b0;
            busy           <= 1'b1;
            lfsr_enable    <= 1'b1;
            lfsr_seed_dv   <= 1'b1;
            lfsr_seed_data <= fix_seed(seed_src);
            operand_r      <= in_data;
            ones_count     <= {WIDTH{1'b0}};
            cnt_r          <= {WIDTH{1'b0}};
          end else begin
            in_ready    <= 1'b1;
            lfsr_enable <= 1'b0;
          end
        end
        S_SEED: begin
          state        <= S_RUN;
          lfsr_seed_dv <= 1'b0;
          bit_valid    <= 1'b0;
        end
        S_RUN: begin
          bit_out    <= cmp;
          bit_valid  <= 1'b1;
          ones_count <= ones_count + {{(WIDTH-1){1'b0}}, cmp};
          cnt_r      <= cnt_r + {{(WIDTH-1){1'b0}}, 1'b1};
          if (cnt_r == CNT_LAST) begin
            state       <= S_DONE;
            done        <= 1'b1;
            busy        <= 1'b0;
            lfsr_enable <= 1'b0;
          end else begin
            state <= S_RUN;
          end
        end
        S_DONE: begin
          state     <= S_IDLE;
          done      <= 1'b0;
          bit_valid <= 1'b0;
          in_ready  <= 1'b1;
        end
        default: begin
          state        <= S_IDLE;
          in_ready     <= 1'b1;
          lfsr_enable  <= 1'b0;
          lfsr_seed_dv <= 1'b0;
          bit_valid    <= 1'b0;
          busy         <= 1'b0;
          done         <= 1'b0;
        end
      endcase
    end
  end

endmodule
